// File: rtl/trackball_pkg.sv
// Shared types and constants for the trackball delta-to-step converter.
// Speed codes map to accumulator shifts; one output step is STEP_UNIT accumulator LSBs.
package trackball_pkg;

    typedef enum logic [1:0] {
        SPD_100 = 2'b00,
        SPD_200 = 2'b01,
        SPD_25  = 2'b10,
        SPD_50  = 2'b11
    } speed_e;

    typedef enum logic {
        MODE_DIRCLK = 1'b0,
        MODE_QUAD   = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STEP,
        ST_HOLD
    } state_e;

    localparam int unsigned STEP_UNIT = 4;

    // Accumulator carries 2 fractional bits, so 100% is a shift of 2.
    function automatic logic [1:0] speed_shift(input speed_e spd);
        logic [1:0] sh;
        case (spd)
            SPD_100: sh = 2'd2;
            SPD_200: sh = 2'd3;
            SPD_25:  sh = 2'd0;
            SPD_50:  sh = 2'd1;
            default: sh = 2'd2;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: saturating scaled accumulator, step pacing FSM and
// dir/clk or quadrature output encoder.
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int unsigned DELTA_W  = 9,
    parameter int unsigned ACC_W    = 14,
    parameter int unsigned STEP_DIV = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               delta_stb_i,
    input  logic [DELTA_W-1:0] delta_i,
    input  logic               flip_i,
    input  speed_e             speed_i,
    input  mode_e              mode_i,
    input  logic               ovf_clr_i,
    output logic               dir_o,
    output logic               clk_o,
    output logic               busy_o,
    output logic               overflow_o
);

    localparam int unsigned SUM_W = ACC_W + 3;
    localparam int unsigned CNT_W = $clog2(STEP_DIV);
    localparam logic signed [SUM_W-1:0] UNIT    = SUM_W'(STEP_UNIT);
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic [CNT_W-1:0]        HOLD_LOAD = CNT_W'(STEP_DIV - 4);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    sign_q, sign_d;
    logic                    dir_q, dir_d;
    logic                    clk_q, clk_d;
    logic                    ovf_q, ovf_d;
    logic [1:0]              phase_q, phase_d;
    logic [CNT_W-1:0]        hold_q, hold_d;

    logic signed [SUM_W-1:0] acc_ext, delta_ext, scaled, step_sub, sum;
    logic                    pend_pos, pend_neg, clip_hi, clip_lo;

    always_comb begin
        acc_ext   = SUM_W'(acc_q);
        delta_ext = SUM_W'(signed'(delta_i));
        if (flip_i) begin
            delta_ext = -delta_ext;
        end
        scaled   = delta_stb_i ? (delta_ext <<< speed_shift(speed_i)) : '0;
        step_sub = '0;
        if (state_q == ST_STEP) begin
            step_sub = sign_q ? UNIT : -UNIT;
        end
        sum     = acc_ext + scaled - step_sub;
        clip_hi = sum > ACC_MAX;
        clip_lo = sum < ACC_MIN;
        if (clip_hi) begin
            acc_d = ACC_MAX[ACC_W-1:0];
        end else if (clip_lo) begin
            acc_d = ACC_MIN[ACC_W-1:0];
        end else begin
            acc_d = sum[ACC_W-1:0];
        end
        ovf_d    = (ovf_q & ~ovf_clr_i) | clip_hi | clip_lo;
        pend_pos = acc_ext >= UNIT;
        pend_neg = acc_ext <= -UNIT;
    end

    // Outputs are registered, so each state's output action is computed on the
    // transition into that state (dir on IDLE->SETUP, step edge on SETUP->STEP).
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        dir_d   = dir_q;
        clk_d   = clk_q;
        phase_d = phase_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_pos || pend_neg) begin
                    sign_d = pend_pos;
                    if (mode_i == MODE_DIRCLK) begin
                        dir_d = pend_pos;
                    end
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (mode_i == MODE_DIRCLK) begin
                    clk_d = ~clk_q;
                end else begin
                    phase_d = sign_q ? phase_q + 2'd1 : phase_q - 2'd1;
                    clk_d   = phase_d[1];
                    dir_d   = phase_d[1] ^ phase_d[0];
                end
                state_d = ST_STEP;
            end
            ST_STEP: begin
                hold_d  = HOLD_LOAD;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            sign_q  <= 1'b0;
            dir_q   <= 1'b0;
            clk_q   <= 1'b0;
            ovf_q   <= 1'b0;
            phase_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
            dir_q   <= dir_d;
            clk_q   <= clk_d;
            ovf_q   <= ovf_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
        end
    end

    assign dir_o      = dir_q;
    assign clk_o      = clk_q;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q != ST_IDLE) || pend_pos || pend_neg;

endmodule

// File: rtl/trackball_quad.sv
// Multi-axis trackball converter: reset synchroniser, delta unpacking and one
// trackball_axis per axis.
module trackball_quad
    import trackball_pkg::*;
#(
    parameter int unsigned AXES     = 2,
    parameter int unsigned DELTA_W  = 9,
    parameter int unsigned ACC_W    = 14,
    parameter int unsigned STEP_DIV = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    delta_stb_i,
    input  logic [AXES*DELTA_W-1:0] delta_i,
    input  logic [AXES-1:0]         flip_i,
    input  logic [1:0]              speed_i,
    input  logic                    mode_i,
    input  logic                    ovf_clr_i,
    output logic [AXES-1:0]         dir_o,
    output logic [AXES-1:0]         clk_o,
    output logic [AXES-1:0]         busy_o,
    output logic [AXES-1:0]         overflow_o
);

    logic   rst_meta_q, rst_sync_q;
    speed_e speed;
    mode_e  mode;

    // Asserts asynchronously, releases two clocks after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign speed = speed_e'(speed_i);
    assign mode  = mode_e'(mode_i);

    for (genvar k = 0; k < AXES; k++) begin : g_axis
        trackball_axis #(
            .DELTA_W  (DELTA_W),
            .ACC_W    (ACC_W),
            .STEP_DIV (STEP_DIV)
        ) u_axis (
            .clk         (clk),
            .rst_n       (rst_sync_q),
            .delta_stb_i (delta_stb_i),
            .delta_i     (delta_i[k*DELTA_W +: DELTA_W]),
            .flip_i      (flip_i[k]),
            .speed_i     (speed),
            .mode_i      (mode),
            .ovf_clr_i   (ovf_clr_i),
            .dir_o       (dir_o[k]),
            .clk_o       (clk_o[k]),
            .busy_o      (busy_o[k]),
            .overflow_o  (overflow_o[k])
        );
    end

endmodule

// File: tb/tb_trackball_quad.sv
// Bench for trackball_quad: stimulus pushes predicted step events per axis into
// queues; a negedge monitor pops and compares each observed output step.
module tb_trackball_quad;

    localparam int AXES     = 2;
    localparam int DELTA_W  = 9;
    localparam int ACC_W    = 14;
    localparam int STEP_DIV = 256;
    localparam int ACC_LIM  = (1 << (ACC_W - 1)) - 1;
    localparam int DRAIN_MAX = 20000;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    delta_stb_i = 1'b0;
    logic [AXES*DELTA_W-1:0] delta_i = '0;
    logic [AXES-1:0]         flip_i = '0;
    logic [1:0]              speed_i = 2'b00;
    logic                    mode_i = 1'b0;
    logic                    ovf_clr_i = 1'b0;
    logic [AXES-1:0]         dir_o, clk_o, busy_o, overflow_o;

    trackball_quad #(
        .AXES     (AXES),
        .DELTA_W  (DELTA_W),
        .ACC_W    (ACC_W),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .delta_stb_i (delta_stb_i),
        .delta_i     (delta_i),
        .flip_i      (flip_i),
        .speed_i     (speed_i),
        .mode_i      (mode_i),
        .ovf_clr_i   (ovf_clr_i),
        .dir_o       (dir_o),
        .clk_o       (clk_o),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint   cyc;
        bit       s;
        bit [1:0] ab;
    } ev_t;

    ev_t      q0[$];
    ev_t      q1[$];
    int       n_vec = 0;
    int       n_err = 0;
    bit       mon_en = 1'b1;
    longint   m_acc[AXES];
    longint   m_last[AXES];
    int       m_phase[AXES];
    bit [1:0] gray[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    bit [1:0] prev_ab[AXES];

    function automatic void chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < AXES; k++) begin
            m_acc[k]   = 0;
            m_last[k]  = -100000;
            m_phase[k] = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    // Reference: scaled delta adds to a fractional count; every whole unit of 4
    // becomes one step, no sooner than 3 cycles after the strobe and no closer
    // than STEP_DIV cycles to the previous step on that axis.
    function automatic void model_strobe(input int k, input int d, input bit flip,
                                         input logic [1:0] spd, input bit quad, input longint t);
        int     factor;
        bit     s;
        ev_t    e;
        case (spd)
            2'b00:   factor = 4;
            2'b01:   factor = 8;
            2'b10:   factor = 1;
            default: factor = 2;
        endcase
        m_acc[k] += longint'((flip ? -d : d) * factor);
        if (m_acc[k] > ACC_LIM) m_acc[k] = ACC_LIM;
        if (m_acc[k] < -ACC_LIM) m_acc[k] = -ACC_LIM;
        while (m_acc[k] >= 4 || m_acc[k] <= -4) begin
            s = m_acc[k] > 0;
            m_acc[k] -= s ? 4 : -4;
            e.cyc = (t + 3 > m_last[k] + STEP_DIV) ? t + 3 : m_last[k] + STEP_DIV;
            m_last[k] = e.cyc;
            if (quad) m_phase[k] = (m_phase[k] + (s ? 1 : 3)) % 4;
            e.s  = s;
            e.ab = gray[m_phase[k]];
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < AXES; k++) prev_ab[k] = 2'b00;
        end else begin
            for (int k = 0; k < AXES; k++) begin
                bit [1:0] ab;
                bit       hit;
                int       qs;
                ev_t      e;
                ab  = {clk_o[k], dir_o[k]};
                hit = mode_i ? (ab != prev_ab[k]) : (ab[1] != prev_ab[k][1]);
                if (hit && mon_en) begin
                    qs = (k == 0) ? q0.size() : q1.size();
                    chk($sformatf("step expected axis%0d", k), (qs > 0) ? 1 : 0, 1);
                    if (qs > 0) begin
                        if (k == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk($sformatf("step cycle axis%0d", k), cyc, e.cyc);
                        if (mode_i) chk($sformatf("quad AB axis%0d", k), ab, e.ab);
                        else        chk($sformatf("dir axis%0d", k), dir_o[k], e.s);
                    end
                end
                prev_ab[k] = ab;
            end
        end
    end

    task automatic strobe(input int d0, input int d1);
        @(posedge clk); #1;
        delta_i     = {DELTA_W'(d1), DELTA_W'(d0)};
        delta_stb_i = 1'b1;
        if (mon_en) begin
            model_strobe(0, d0, flip_i[0], speed_i, mode_i, cyc);
            model_strobe(1, d1, flip_i[1], speed_i, mode_i, cyc);
        end
        @(posedge clk); #1;
        delta_stb_i = 1'b0;
        delta_i     = '0;
    endtask

    task automatic wait_until(input longint c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy_o != '0) && n < DRAIN_MAX) begin
            @(negedge clk);
            n++;
        end
        chk({name, " drain timeout"}, (n >= DRAIN_MAX) ? 1 : 0, 0);
        if (n >= DRAIN_MAX) model_reset();
    endtask

    task automatic do_reset(input bit quad);
        @(posedge clk); #1;
        reset_n = 1'b0;
        mode_i  = quad;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    task automatic rand_burst(input string name);
        bit [1:0] neg;
        int       ns;
        int       m0, m1;
        speed_i = 2'($urandom_range(0, 3));
        flip_i  = 2'($urandom_range(0, 3));
        neg     = 2'($urandom_range(0, 3));
        ns      = $urandom_range(1, 2);
        for (int i = 0; i < ns; i++) begin
            m0 = $urandom_range(0, 2);
            m1 = $urandom_range(0, 2);
            strobe(neg[0] ? -m0 : m0, neg[1] ? -m1 : m1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_idle(name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint last;
        longint first;
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dir_o", dir_o, 0);
        chk("reset clk_o", clk_o, 0);
        chk("reset busy_o", busy_o, 0);
        chk("reset overflow_o", overflow_o, 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // dir/clk, 100%: +3 -> three positive steps STEP_DIV apart
        mode_i = 1'b0; speed_i = 2'b00; flip_i = '0;
        strobe(3, 0);
        last = m_last[0];
        wait_until(last + 253);
        chk("busy in last hold", busy_o[0], 1);
        @(negedge clk);
        chk("busy after last hold", busy_o[0], 0);
        chk("dir after +3", dir_o[0], 1);
        chk("steps left after +3", q0.size(), 0);

        // 25%: three +1 strobes stay fractional, fourth yields one step
        speed_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            strobe(1, 0);
            repeat (10) @(posedge clk);
        end
        repeat (20) @(posedge clk);
        #1;
        chk("quarter speed fraction busy", busy_o[0], 0);
        strobe(1, 0);
        wait_idle("quarter speed");

        // flip on axis1 turns +5 into five negative steps; axis0 idle
        speed_i = 2'b00; flip_i = 2'b10;
        strobe(0, 5);
        repeat (10) @(posedge clk);
        #1;
        chk("flip axis0 idle", busy_o[0], 0);
        chk("flip axis1 busy", busy_o[1], 1);
        wait_idle("flip");
        flip_i = '0;

        for (int b = 0; b < 6; b++) rand_burst("random dirclk");

        // saturation and sticky overflow; step checking off
        mon_en = 1'b0; speed_i = 2'b01; flip_i = '0;
        for (int i = 0; i < 4; i++) strobe(255, 0);
        chk("no overflow below limit", overflow_o[0], 0);
        strobe(255, 0);
        chk("overflow on clip", overflow_o[0], 1);
        chk("overflow other axis", overflow_o[1], 0);
        repeat (3) @(posedge clk);
        #1;
        chk("overflow sticky", overflow_o[0], 1);
        ovf_clr_i = 1'b1;
        @(posedge clk); #1;
        ovf_clr_i = 1'b0;
        chk("overflow cleared", overflow_o[0], 0);
        @(posedge clk); #1;
        ovf_clr_i   = 1'b1;
        delta_stb_i = 1'b1;
        delta_i     = {DELTA_W'(0), DELTA_W'(255)};
        @(posedge clk); #1;
        ovf_clr_i   = 1'b0;
        delta_stb_i = 1'b0;
        delta_i     = '0;
        chk("overflow clear vs clip", overflow_o[0], 1);

        // quadrature: +2 then -2 walks the Gray sequence forward and back
        do_reset(1'b1);
        chk("overflow after reset", overflow_o[0], 0);
        speed_i = 2'b00; flip_i = '0;
        strobe(2, 0);
        wait_idle("quad fwd");
        chk("quad AB after +2", {clk_o[0], dir_o[0]}, 2'b11);
        strobe(-2, 0);
        wait_idle("quad back");
        chk("quad AB after -2", {clk_o[0], dir_o[0]}, 2'b00);

        for (int b = 0; b < 6; b++) rand_burst("random quad");

        // reset in the middle of a HOLD with acc=40 outstanding
        do_reset(1'b0);
        speed_i = 2'b00; flip_i = '0;
        strobe(10, 0);
        first = q0[0].cyc;
        wait_until(first + 10);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("mid-hold reset clk_o", clk_o, 0);
        chk("mid-hold reset dir_o", dir_o, 0);
        chk("mid-hold reset busy_o", busy_o, 0);
        chk("mid-hold reset overflow_o", overflow_o, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("idle after reset release", busy_o, 0);
        chk("residual clk_o after reset", clk_o, 0);

        chk("unconsumed steps axis0", q0.size(), 0);
        chk("unconsumed steps axis1", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
